// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: per-stage valid chain with stall freeze, redirect flush and load-use bubble.
// Optional PIPE_PERF_EN adds saturating stall/flush/bubble event counters.
module pipe_hazard_ctrl #(
   parameter int unsigned STAGES        = 5,
   parameter int unsigned RESOLVE_STAGE = 2,
   parameter int unsigned RW            = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              icache_stall,
   input  logic              dcache_stall,
   input  logic              fetch_valid,
   input  logic              redirect,
   input  logic [RW-1:0]     dec_rs1,
   input  logic [RW-1:0]     dec_rs2,
   input  logic              dec_rs1_used,
   input  logic              dec_rs2_used,
   input  logic              ex_is_load,
   input  logic [RW-1:0]     ex_rd,
   output logic [STAGES-1:0] stage_valid,
   output logic [STAGES-1:0] hold_mask,
   output logic              flush,
   output logic              bubble,
   output logic              commit
`ifdef PIPE_PERF_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_flush_cnt,
   output logic [31:0]       perf_bubble_cnt
`endif
);

   logic [STAGES-1:0] stage_valid_q, stage_valid_d;
   logic              advance;
   logic              redir_ok;
   logic              lu_haz;

   assign advance  = ~(icache_stall | dcache_stall);
   assign redir_ok = redirect & stage_valid_q[RESOLVE_STAGE];
   // x0 is hard-wired, so a load targeting it never creates a dependency
   assign lu_haz   = stage_valid_q[1] & stage_valid_q[2] & ex_is_load & (ex_rd != '0) &
                     ((dec_rs1_used & (dec_rs1 == ex_rd)) | (dec_rs2_used & (dec_rs2 == ex_rd)));

   always_comb begin
      stage_valid_d = stage_valid_q;
      hold_mask     = '0;
      flush         = 1'b0;
      bubble        = 1'b0;
      if (!advance) begin
         hold_mask = '1;
      end else if (redir_ok) begin
         flush = 1'b1;
         stage_valid_d[0] = 1'b0;
         for (int unsigned k = 1; k < STAGES; k++) begin
            stage_valid_d[k] = (k <= RESOLVE_STAGE) ? 1'b0 : stage_valid_q[k-1];
         end
      end else if (lu_haz) begin
         // fetch and decode hold; a bubble enters execute while older stages drain
         bubble        = 1'b1;
         hold_mask[1:0] = 2'b11;
         stage_valid_d[2] = 1'b0;
         for (int unsigned k = 3; k < STAGES; k++) begin
            stage_valid_d[k] = stage_valid_q[k-1];
         end
      end else begin
         stage_valid_d[0] = fetch_valid;
         for (int unsigned k = 1; k < STAGES; k++) begin
            stage_valid_d[k] = stage_valid_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stage_valid_q <= '0;
      else      stage_valid_q <= stage_valid_d;
   end

   assign stage_valid = stage_valid_q;
   assign commit      = advance & stage_valid_q[STAGES-1];

`ifdef PIPE_PERF_EN
   logic [31:0] perf_stall_cnt_q,  perf_stall_cnt_d;
   logic [31:0] perf_flush_cnt_q,  perf_flush_cnt_d;
   logic [31:0] perf_bubble_cnt_q, perf_bubble_cnt_d;

   always_comb begin
      perf_stall_cnt_d  = perf_stall_cnt_q;
      perf_flush_cnt_d  = perf_flush_cnt_q;
      perf_bubble_cnt_d = perf_bubble_cnt_q;
      if (!advance && perf_stall_cnt_q != '1) perf_stall_cnt_d  = perf_stall_cnt_q + 32'd1;
      if (flush    && perf_flush_cnt_q != '1) perf_flush_cnt_d  = perf_flush_cnt_q + 32'd1;
      if (bubble   && perf_bubble_cnt_q != '1) perf_bubble_cnt_d = perf_bubble_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cnt_q  <= '0;
         perf_flush_cnt_q  <= '0;
         perf_bubble_cnt_q <= '0;
      end else begin
         perf_stall_cnt_q  <= perf_stall_cnt_d;
         perf_flush_cnt_q  <= perf_flush_cnt_d;
         perf_bubble_cnt_q <= perf_bubble_cnt_d;
      end
   end

   assign perf_stall_cnt  = perf_stall_cnt_q;
   assign perf_flush_cnt  = perf_flush_cnt_q;
   assign perf_bubble_cnt = perf_bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (STAGES=5, RESOLVE_STAGE=2); perf checks when PIPE_PERF_EN is defined.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       icache_stall, dcache_stall, fetch_valid, redirect;
   logic [4:0] dec_rs1, dec_rs2, ex_rd;
   logic       dec_rs1_used, dec_rs2_used, ex_is_load;
   logic [4:0] stage_valid, hold_mask;
   logic       flush, bubble, commit;
`ifdef PIPE_PERF_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.STAGES(5), .RESOLVE_STAGE(2), .RW(5)) dut (
      .clk(clk), .rst(rst),
      .icache_stall(icache_stall), .dcache_stall(dcache_stall),
      .fetch_valid(fetch_valid), .redirect(redirect),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .stage_valid(stage_valid), .hold_mask(hold_mask),
      .flush(flush), .bubble(bubble), .commit(commit)
`ifdef PIPE_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
      .perf_bubble_cnt(perf_bubble_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [4:0] sv, input logic [4:0] hm,
                             input logic fl, input logic bu, input logic cm);
      #2;
      check({tag, "/valid"},  {27'd0, stage_valid}, {27'd0, sv});
      check({tag, "/hold"},   {27'd0, hold_mask},   {27'd0, hm});
      check({tag, "/flush"},  {31'd0, flush},       {31'd0, fl});
      check({tag, "/bubble"}, {31'd0, bubble},      {31'd0, bu});
      check({tag, "/commit"}, {31'd0, commit},      {31'd0, cm});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_hazard();
      redirect = 0; ex_is_load = 0; ex_rd = 0;
      dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0; dec_rs2_used = 0;
   endtask

   // expected valid while the pipe refills from empty with fetch_valid held high
   logic [4:0] fill_tbl [0:5] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};

   initial begin
      rst = 0; icache_stall = 0; dcache_stall = 0; fetch_valid = 0;
      clear_hazard();
      tick(); tick();
      check_outs("reset", 5'b00000, 5'b00000, 0, 0, 0);
      rst = 1;
      tick();

      // 1: continuous fetch, first commit after five advancing edges
      fetch_valid = 1;
      for (int i = 0; i < 5; i++) begin
         check_outs($sformatf("fill%0d", i), fill_tbl[i], 5'b00000, 0, 0, 0);
         tick();
      end
      check_outs("fill5", 5'b11111, 5'b00000, 0, 0, 1);
      tick();
      check_outs("steady", 5'b11111, 5'b00000, 0, 0, 1);

      // 2: redirect with stage 2 valid; stages 0..2 squashed, 3 and 4 keep draining
      redirect = 1;
      check_outs("redir", 5'b11111, 5'b00000, 1, 0, 1);
      tick(); redirect = 0;
      check_outs("redir+1", 5'b11000, 5'b00000, 0, 0, 1);
      tick();
      check_outs("redir+2", 5'b10001, 5'b00000, 0, 0, 1);
      tick();
      check_outs("gap1", 5'b00011, 5'b00000, 0, 0, 0);
      tick();
      check_outs("gap2", 5'b00111, 5'b00000, 0, 0, 0);
      tick();
      check_outs("gap3", 5'b01111, 5'b00000, 0, 0, 0);
      tick();
      check_outs("regain", 5'b11111, 5'b00000, 0, 0, 1);

      // 3: load-use on rs2
      ex_is_load = 1; ex_rd = 5; dec_rs2 = 5; dec_rs2_used = 1;
      check_outs("lu_rs2", 5'b11111, 5'b00011, 0, 1, 1);
      tick(); ex_is_load = 0;
      check_outs("lu+1", 5'b11011, 5'b00000, 0, 0, 1);
      tick(); clear_hazard();
      check_outs("lu+2", 5'b10111, 5'b00000, 0, 0, 1);
      tick();
      check_outs("lu+3", 5'b01111, 5'b00000, 0, 0, 0);
      tick();
      check_outs("lu+4", 5'b11111, 5'b00000, 0, 0, 1);

      // 4: x0 destination is never a hazard; rs1 match is; redirect beats load-use
      ex_is_load = 1; ex_rd = 0; dec_rs1 = 0; dec_rs1_used = 1;
      check_outs("x0", 5'b11111, 5'b00000, 0, 0, 1);
      ex_rd = 3; dec_rs1 = 3;
      check_outs("lu_rs1", 5'b11111, 5'b00011, 0, 1, 1);
      redirect = 1;
      check_outs("redir_lu", 5'b11111, 5'b00000, 1, 0, 1);
      tick(); clear_hazard();
      check_outs("redir_lu+1", 5'b11000, 5'b00000, 0, 0, 1);
      for (int i = 0; i < 5; i++) tick();
      check_outs("refill", 5'b11111, 5'b00000, 0, 0, 1);

      // 5: redirect held through a stall acts on the first advancing cycle
      redirect = 1; dcache_stall = 1;
      for (int i = 0; i < 4; i++) begin
         check_outs($sformatf("dstall%0d", i), 5'b11111, 5'b11111, 0, 0, 0);
         tick();
      end
      dcache_stall = 0; icache_stall = 1;
      check_outs("istall", 5'b11111, 5'b11111, 0, 0, 0);
      tick(); icache_stall = 0;
      check_outs("stall_redir", 5'b11111, 5'b00000, 1, 0, 1);
      tick(); redirect = 0;
      check_outs("stall_redir+1", 5'b11000, 5'b00000, 0, 0, 1);
      tick();
`ifdef PIPE_PERF_EN
      #2;
      check("perf_stall", perf_stall_cnt, 32'd5);
      check("perf_flush", perf_flush_cnt, 32'd3);
      check("perf_bubble", perf_bubble_cnt, 32'd1);
`endif
      #2; rst = 0; #1;
      check_outs("async_rst", 5'b00000, 5'b00000, 0, 0, 0);
`ifdef PIPE_PERF_EN
      check("perf_rst", perf_stall_cnt | perf_flush_cnt | perf_bubble_cnt, 32'd0);
`endif
      tick(); tick(); rst = 1;
      for (int i = 0; i < 5; i++) begin
         check_outs($sformatf("post_rst%0d", i), fill_tbl[i], 5'b00000, 0, 0, 0);
         tick();
      end
      check_outs("post_rst5", 5'b11111, 5'b00000, 0, 0, 1);

`ifdef PIPE_PERF_EN
      // 6: stall counter saturates
      force dut.perf_stall_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.perf_stall_cnt_q;
      dcache_stall = 1;
      tick(); tick();
      dcache_stall = 0;
      #2;
      check("perf_sat", perf_stall_cnt, 32'hFFFF_FFFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
